monolith_bars_folded: RTL and testbench

//   Time-multiplexed Monolith Bars layer with valid/ready handshake on both sides.

---
 rtl/monolith_pkg.sv | 21 ++
 rtl/m31_mod_reduce.sv | 20 ++
 rtl/monolith_bars_lane.sv | 48 ++++
 rtl/monolith_bars_folded.sv | 133 +++++++++++++
 tb/tb_monolith_bars_folded.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/monolith_pkg.sv
// Shared constants, FSM encoding and sizing helpers for the folded Monolith Bars layer.
package monolith_pkg;

  localparam logic [30:0] M31_P = 31'h7FFFFFFF;
  localparam int DEFAULT_CHUNK = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PROC = 2'd1,
    ST_DONE = 2'd2
  } bars_state_e;

  function automatic int num_chunks(input int w, input int c);
    return (w + c - 1) / c;
  endfunction

  function automatic int num_groups(input int n, input int l);
    return (n + l - 1) / l;
  endfunction

endpackage

// File: rtl/m31_mod_reduce.sv
// Maps a word into [0, M31_P): the only out-of-range encoding for widths up to 31 is M31_P itself.
module m31_mod_reduce
  import monolith_pkg::*;
#(
  parameter int W = 31
) (
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);

  logic [31:0] x32;
  logic [31:0] r32;

  always_comb begin
    x32 = 32'(x);
    r32 = (x32 >= 32'(M31_P)) ? (x32 - 32'(M31_P)) : x32;
    y   = r32[W-1:0];
  end

endmodule

// File: rtl/monolith_bars_lane.sv
// One Bars word-lane: the word is split into CHUNK-bit pieces (top piece takes the remainder),
// each passed through the Monolith chi-like S-box.
module monolith_sbox #(
  parameter int W = 8
) (
  input  logic [W-1:0] y,
  output logic [W-1:0] s
);

  localparam int K1 = 1 % W;
  localparam int K2 = 2 % W;
  localparam int K3 = 3 % W;

  function automatic logic [W-1:0] rotl(input logic [W-1:0] v, input int k);
    return (v << k) | (v >> ((W - k) % W));
  endfunction

  logic [W-1:0] t;

  always_comb begin
    t = y ^ (rotl(~y, K1) & rotl(y, K2) & rotl(y, K3));
    s = rotl(t, K1);
  end

endmodule

module monolith_bars_lane
  import monolith_pkg::*;
#(
  parameter int WORD_WIDTH = 31,
  parameter int CHUNK      = DEFAULT_CHUNK
) (
  input  logic [WORD_WIDTH-1:0] word_in,
  output logic [WORD_WIDTH-1:0] word_out
);

  localparam int NC  = num_chunks(WORD_WIDTH, CHUNK);
  localparam int TOP = WORD_WIDTH - CHUNK * (NC - 1);

  for (genvar c = 0; c < NC; c++) begin : g_chunk
    localparam int CW = (c == NC - 1) ? TOP : CHUNK;
    monolith_sbox #(.W(CW)) u_sbox (
      .y(word_in[c*CHUNK +: CW]),
      .s(word_out[c*CHUNK +: CW])
    );
  end

endmodule

// File: rtl/monolith_bars_folded.sv
// Time-multiplexed Bars layer: LANES words are S-boxed per PROC cycle over NG cycles.
// Handshake: a transfer happens on a rising edge where valid && ready; ready never depends on valid.
module monolith_bars_folded
  import monolith_pkg::*;
#(
  parameter int WORD_WIDTH   = 31,
  parameter int STATE_SIZE   = 16,
  parameter int BAR_OP_COUNT = 8,
  parameter int LANES        = 4,
  parameter int CHUNK        = DEFAULT_CHUNK,
  parameter int REDUCE       = 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0]  state_in,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [STATE_SIZE-1:0][WORD_WIDTH-1:0]  state_out,
  output logic                                   busy,
  output logic [1:0]                             dbg_state
);

  localparam int NG = num_groups(BAR_OP_COUNT, LANES);
  localparam int GW = (NG > 1) ? $clog2(NG) : 1;

  if (BAR_OP_COUNT < 1 || BAR_OP_COUNT > STATE_SIZE) begin : g_bad_boc
    $error("BAR_OP_COUNT must be in 1..STATE_SIZE");
  end
  if (LANES < 1 || LANES > BAR_OP_COUNT) begin : g_bad_lanes
    $error("LANES must be in 1..BAR_OP_COUNT");
  end
  if (WORD_WIDTH < 1 || WORD_WIDTH > 31 || CHUNK < 1) begin : g_bad_width
    $error("WORD_WIDTH must be in 1..31 and CHUNK positive");
  end

  bars_state_e             state_q, state_d;
  logic [GW-1:0]           grp_q, grp_d;
  logic [WORD_WIDTH-1:0]   data_q [STATE_SIZE];
  logic [WORD_WIDTH-1:0]   data_d [STATE_SIZE];

  logic [LANES-1:0][WORD_WIDTH-1:0] lane_in;
  logic [LANES-1:0][WORD_WIDTH-1:0] lane_out;
  int                               lane_idx [LANES];

  // Lane input mux; indices past the state vector feed zero.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_idx[l] = int'(grp_q) * LANES + l;
      lane_in[l]  = '0;
      for (int w = 0; w < STATE_SIZE; w++) begin
        if (lane_idx[l] == w) lane_in[l] = data_q[w];
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    monolith_bars_lane #(.WORD_WIDTH(WORD_WIDTH), .CHUNK(CHUNK)) u_lane (
      .word_in (lane_in[l]),
      .word_out(lane_out[l])
    );
  end

  always_comb begin
    state_d  = state_q;
    grp_d    = grp_q;
    data_d   = data_q;
    in_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          for (int w = 0; w < STATE_SIZE; w++) data_d[w] = state_in[w];
          grp_d   = '0;
          state_d = ST_PROC;
        end
      end
      ST_PROC: begin
        // Only S-box words get written; lanes beyond BAR_OP_COUNT idle.
        for (int w = 0; w < BAR_OP_COUNT; w++) begin
          for (int l = 0; l < LANES; l++) begin
            if (lane_idx[l] == w) data_d[w] = lane_out[l];
          end
        end
        grp_d = grp_q + GW'(1);
        if (grp_q == GW'(NG - 1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          in_ready = 1'b1;
          if (in_valid) begin
            for (int w = 0; w < STATE_SIZE; w++) data_d[w] = state_in[w];
            grp_d   = '0;
            state_d = ST_PROC;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!reset) in_ready = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      grp_q   <= '0;
      data_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

  for (genvar w = 0; w < STATE_SIZE; w++) begin : g_out
    if (REDUCE != 0) begin : g_red
      m31_mod_reduce #(.W(WORD_WIDTH)) u_red (
        .x(data_q[w]),
        .y(state_out[w])
      );
    end else begin : g_raw
      assign state_out[w] = data_q[w];
    end
  end

endmodule

// File: tb/tb_monolith_bars_folded.sv
// Directed bench for monolith_bars_folded: four parameterisations driven from shared clock/reset.
module tb_monolith_bars_folded;

  typedef logic [15:0][30:0] state_t;
  localparam logic [30:0] P = 31'h7FFFFFFF;

  // 0: defaults, 1: REDUCE=0, 2: LANES=3, 3: LANES=1
  logic       clk;
  logic       reset;
  logic [3:0] in_valid, in_ready, out_valid, out_ready, busy;
  logic [1:0] dbg [4];
  state_t     state_in;
  state_t     state_out [4];

  int total = 0;
  int bad   = 0;

  monolith_bars_folded u_d0 (
    .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .state_in(state_in), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .state_out(state_out[0]), .busy(busy[0]), .dbg_state(dbg[0]));
  monolith_bars_folded #(.REDUCE(0)) u_d1 (
    .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .state_in(state_in), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .state_out(state_out[1]), .busy(busy[1]), .dbg_state(dbg[1]));
  monolith_bars_folded #(.LANES(3)) u_d2 (
    .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .state_in(state_in), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .state_out(state_out[2]), .busy(busy[2]), .dbg_state(dbg[2]));
  monolith_bars_folded #(.LANES(1)) u_d3 (
    .clk(clk), .reset(reset), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .state_in(state_in), .out_valid(out_valid[3]), .out_ready(out_ready[3]),
    .state_out(state_out[3]), .busy(busy[3]), .dbg_state(dbg[3]));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Hand-computed Bars results for the words used below.
  function automatic logic [30:0] exp_word(input logic [30:0] x, input int idx, input bit red);
    logic [30:0] r;
    if (idx >= 8) r = x;
    else begin
      case (x)
        31'h00000000: r = 31'h00000000;
        31'h00000001: r = 31'h00000002;
        31'h01010101: r = 31'h02020202;
        31'h03070103: r = 31'h162E0216;
        31'h7FFFFFFF: r = 31'h7FFFFFFF;
        default:      r = 'x;
      endcase
    end
    if (red && r == P) r = '0;
    return r;
  endfunction

  task automatic check_state(input string tag, input int d, input state_t s);
    for (int i = 0; i < 16; i++)
      check($sformatf("%s_w%0d", tag, i), 64'(state_out[d][i]), 64'(exp_word(s[i], i, d != 1)));
  endtask

  // Drive one transaction with out_ready=1 and check latency, result and drain.
  task automatic do_txn(input int d, input state_t s, input int ng, input string tag);
    int n;
    int lat;
    @(negedge clk);
    state_in    = s;
    in_valid[d] = 1'b1;
    out_ready[d] = 1'b1;
    n = 0;
    while (!in_ready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_in_ready"}, 64'(in_ready[d]), 64'd1);
    @(posedge clk);
    #1 in_valid[d] = 1'b0;
    check({tag, "_busy"}, 64'(busy[d]), 64'd1);
    lat = 1;
    while (!out_valid[d] && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(ng + 1));
    check_state(tag, d, s);
    @(posedge clk);
    #1;
    check({tag, "_drained"}, 64'(out_valid[d]), 64'd0);
    check({tag, "_idle"}, 64'(busy[d]), 64'd0);
  endtask

  state_t s_zero, s_ones, s_single, s_mix, s_b;

  initial begin
    reset     = 1'b0;
    in_valid  = '0;
    out_ready = '0;
    state_in  = '0;

    s_zero = '0;
    for (int i = 0; i < 16; i++) s_ones[i] = P;
    s_single = '0;
    s_single[0] = 31'h1;
    s_single[8] = 31'h1;
    s_mix[0] = 31'h03070103; s_mix[1] = 31'h00000001;
    s_mix[2] = 31'h01010101; s_mix[3] = 31'h7FFFFFFF;
    s_mix[4] = 31'h03070103; s_mix[5] = 31'h00000000;
    s_mix[6] = 31'h00000001; s_mix[7] = 31'h01010101;
    for (int i = 8; i < 16; i++) s_mix[i] = 31'(32'h0ABC0000 + 32'(i));
    s_mix[15] = P;
    s_b = '0;
    s_b[1] = 31'h03070103;
    s_b[6] = 31'h01010101;
    s_b[9] = 31'h00000077;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      check($sformatf("rst_out_valid%0d", d), 64'(out_valid[d]), 64'd0);
      check($sformatf("rst_busy%0d", d), 64'(busy[d]), 64'd0);
      check($sformatf("rst_in_ready%0d", d), 64'(in_ready[d]), 64'd0);
    end
    check("rst_raw_w0", 64'(state_out[1][0]), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_release_ready", 64'(in_ready[0]), 64'd1);

    // all zero, all ones, single bits
    do_txn(0, s_zero, 2, "zero");
    do_txn(0, s_ones, 2, "ones_red");
    do_txn(1, s_ones, 2, "ones_raw");
    do_txn(0, s_single, 2, "single");
    do_txn(0, s_mix, 2, "mix_l4");
    do_txn(1, s_mix, 2, "mix_raw");

    // other lane counts
    do_txn(2, s_mix, 3, "mix_l3");
    do_txn(3, s_mix, 8, "mix_l1");
    do_txn(2, s_b, 3, "b_l3");

    // backpressure in DONE, then back-to-back accept
    @(negedge clk);
    state_in     = s_mix;
    in_valid[0]  = 1'b1;
    out_ready[0] = 1'b0;
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("bp_out_valid", 64'(out_valid[0]), 64'd1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("bp_hold_valid", 64'(out_valid[0]), 64'd1);
      check("bp_in_ready", 64'(in_ready[0]), 64'd0);
      check_state($sformatf("bp_hold%0d", c), 0, s_mix);
    end
    @(negedge clk);
    state_in     = s_b;
    in_valid[0]  = 1'b1;
    out_ready[0] = 1'b1;
    #1;
    check("b2b_in_ready", 64'(in_ready[0]), 64'd1);
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    check("b2b_out_valid", 64'(out_valid[0]), 64'd0);
    check("b2b_state", 64'(dbg[0]), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    check("b2b_done", 64'(out_valid[0]), 64'd1);
    check_state("b2b", 0, s_b);
    @(posedge clk);
    #1;
    check("b2b_drained", 64'(out_valid[0]), 64'd0);

    // reset in the middle of PROC
    @(negedge clk);
    state_in = s_ones;
    in_valid[0] = 1'b1;
    in_valid[1] = 1'b1;
    @(posedge clk);
    #1 in_valid = '0;
    @(posedge clk);
    #1;
    check("midrst_proc", 64'(dbg[0]), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_in_ready", 64'(in_ready[0]), 64'd0);
    @(posedge clk);
    #1;
    check("midrst_state", 64'(dbg[0]), 64'd0);
    check("midrst_out_valid", 64'(out_valid[0]), 64'd0);
    check("midrst_busy", 64'(busy[1]), 64'd0);
    for (int i = 0; i < 16; i++)
      check($sformatf("midrst_buf%0d", i), 64'(state_out[1][i]), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("midrst_no_output", 64'(out_valid[0]), 64'd0);
    do_txn(0, s_single, 2, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
